// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampled, optional parity) feeding a first-word
// fall-through FIFO with framing, parity and overrun error pulses.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int unsigned DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam logic        ODD_PAR = 1'(PARITY == 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PAR       = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  // Receiver state
  state_t             state_q, state_d;
  logic               rx_s1_q, rx_s1_d;
  logic               rx_s2_q, rx_s2_d;
  logic               rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]         tick_cnt_q, tick_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_ok_q, par_ok_d;
  logic               frame_err_q, frame_err_d;
  logic               parity_err_q, parity_err_d;

  // FIFO state
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               overrun_q, overrun_d;

  logic               tick_c;
  logic               good_c;
  logic               rd_fire_c;
  logic               wr_fire_c;

  // Oversample tick: one clk pulse every DIV clocks
  assign tick_c = (div_cnt_q == DIV_W'(DIV - 1));

  // Synchronizer, tick phase and frame-decoding FSM next state
  always_comb begin
    state_d      = state_q;
    rx_s1_d      = rx;
    rx_s2_d      = rx_s1_q;
    rx_prev_d    = rx_s2_q;
    div_cnt_d    = tick_c ? '0 : div_cnt_q + DIV_W'(1);
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    good_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Falling edge restarts the tick phase so sampling lands mid-bit
        if (rx_prev_q && !rx_s2_q) begin
          state_d    = START;
          div_cnt_d  = '0;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
          par_ok_d   = 1'b1;
        end
      end
      START: begin
        if (tick_c) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            state_d    = rx_s2_q ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d[bit_cnt_q] = rx_s2_q;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
              state_d = (PARITY != 0) ? PAR : STOP;
            end
          end
        end
      end
      PAR: begin
        if (tick_c) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            par_ok_d = (((^shift_q) ^ rx_s2_q) == ODD_PAR);
            state_d  = STOP;
          end
        end
      end
      STOP: begin
        if (tick_c) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            if (!rx_s2_q) begin
              frame_err_d = 1'b1;
              state_d     = WAIT_IDLE;
            end else if (!par_ok_q) begin
              parity_err_d = 1'b1;
              state_d      = IDLE;
            end else begin
              good_c  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s2_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer/count update with first-word fall-through head register
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_fire_c = rd_en && !empty_q;
    wr_fire_c = good_c && (!full_q || rd_fire_c);
    overrun_d = good_c && full_q && !rd_fire_c;

    if (wr_fire_c) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_fire_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({wr_fire_c, rd_fire_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    empty_d   = (count_d == '0);
    full_d    = (count_d == CW'(FIFO_DEPTH));
    rd_data_d = empty_d ? 8'h00 : mem_d[rd_ptr_d];
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      div_cnt_q    <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b1;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      rd_data_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_prev_q    <= rx_prev_d;
      div_cnt_q    <= div_cnt_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      rd_data_q    <= rd_data_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign count      = count_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one no-parity instance and one even-parity
// instance, run at a scaled baud (DIV = 10, 160 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 10_000;
  localparam int unsigned BIT_NS = 1600;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx0, rx1, rd_en0, rd_en1;
  logic [7:0] rd_data0, rd_data1;
  logic       empty0, empty1, full0, full1;
  logic [2:0] count0, count1;
  logic       fe0, fe1, pe0, pe1, ov0, ov1;

  int tests = 0;
  int fails = 0;
  int fe_cnt0 = 0, pe_cnt0 = 0, ov_cnt0 = 0;
  int fe_cnt1 = 0, pe_cnt1 = 0, ov_cnt1 = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .rd_en(rd_en0), .rd_data(rd_data0), .empty(empty0),
    .full(full0), .count(count0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0));

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .rd_en(rd_en1), .rd_data(rd_data1), .empty(empty1),
    .full(full1), .count(count1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1));

  // Pulse counters; a stuck pulse inflates the count
  always @(posedge clk) begin
    if (fe0 === 1'b1) fe_cnt0 <= fe_cnt0 + 1;
    if (pe0 === 1'b1) pe_cnt0 <= pe_cnt0 + 1;
    if (ov0 === 1'b1) ov_cnt0 <= ov_cnt0 + 1;
    if (fe1 === 1'b1) fe_cnt1 <= fe_cnt1 + 1;
    if (pe1 === 1'b1) pe_cnt1 <= pe_cnt1 + 1;
    if (ov1 === 1'b1) ov_cnt1 <= ov_cnt1 + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rx1 = v;
    else     rx0 = v;
  endtask

  task automatic uart_send(input bit sel, input logic [7:0] data, input bit has_par,
                           input bit par_bit, input bit stop_bit);
    drive(sel, 1'b0);
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      drive(sel, data[i]);
      #(BIT_NS);
    end
    if (has_par) begin
      drive(sel, par_bit);
      #(BIT_NS);
    end
    drive(sel, stop_bit);
    #(BIT_NS);
    drive(sel, 1'b1);
    #(2 * BIT_NS);
    @(negedge clk);
  endtask

  task automatic pop(input bit sel);
    @(negedge clk);
    if (sel) rd_en1 = 1'b1;
    else     rd_en0 = 1'b1;
    @(negedge clk);
    rd_en0 = 1'b0;
    rd_en1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx0 = 1'b1; rx1 = 1'b1; rd_en0 = 1'b0; rd_en1 = 1'b0;
    #100;
    @(negedge clk);
    tests++; if (empty0 !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", empty0); end
    tests++; if (full0 !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", full0); end
    tests++; if (count0 !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count0); end
    tests++; if (rd_data0 !== 8'h00) begin fails++; $display("FAIL reset_rd_data: got %h expected 00", rd_data0); end
    tests++; if ({fe0, pe0, ov0, fe1, pe1, ov1} !== 6'b0) begin fails++; $display("FAIL reset_pulses: got %b expected 000000", {fe0, pe0, ov0, fe1, pe1, ov1}); end
    tests++; if (empty1 !== 1'b1) begin fails++; $display("FAIL reset_empty1: got %b expected 1", empty1); end
    rst = 1'b1;
    #(2 * BIT_NS);
  endtask

  task automatic test_single();
    uart_send(1'b0, 8'h72, 1'b0, 1'b0, 1'b1);
    tests++; if (empty0 !== 1'b0) begin fails++; $display("FAIL single_empty: got %b expected 0", empty0); end
    tests++; if (count0 !== 3'd1) begin fails++; $display("FAIL single_count: got %0d expected 1", count0); end
    tests++; if (rd_data0 !== 8'h72) begin fails++; $display("FAIL single_data: got %h expected 72", rd_data0); end
    pop(1'b0);
    tests++; if (empty0 !== 1'b1) begin fails++; $display("FAIL single_pop_empty: got %b expected 1", empty0); end
    tests++; if (count0 !== 3'd0) begin fails++; $display("FAIL single_pop_count: got %0d expected 0", count0); end
  endtask

  task automatic test_glitch();
    int fe_b = fe_cnt0;
    int pe_b = pe_cnt0;
    rx0 = 1'b0;
    #300;
    rx0 = 1'b1;
    #(2 * BIT_NS);
    @(negedge clk);
    tests++; if (empty0 !== 1'b1) begin fails++; $display("FAIL glitch_empty: got %b expected 1", empty0); end
    tests++; if ((fe_cnt0 - fe_b) != 0 || (pe_cnt0 - pe_b) != 0) begin fails++; $display("FAIL glitch_err: got fe %0d pe %0d expected 0 0", fe_cnt0 - fe_b, pe_cnt0 - pe_b); end
    uart_send(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    tests++; if (rd_data0 !== 8'hC3 || count0 !== 3'd1) begin fails++; $display("FAIL glitch_next: got %h/%0d expected c3/1", rd_data0, count0); end
    pop(1'b0);
  endtask

  task automatic test_frame_err();
    int fe_b = fe_cnt0;
    uart_send(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    tests++; if ((fe_cnt0 - fe_b) != 1) begin fails++; $display("FAIL frame_err_pulses: got %0d expected 1", fe_cnt0 - fe_b); end
    tests++; if (empty0 !== 1'b1) begin fails++; $display("FAIL frame_err_empty: got %b expected 1", empty0); end
    uart_send(1'b0, 8'h41, 1'b0, 1'b0, 1'b1);
    tests++; if (rd_data0 !== 8'h41 || count0 !== 3'd1) begin fails++; $display("FAIL frame_err_next: got %h/%0d expected 41/1", rd_data0, count0); end
    pop(1'b0);
  endtask

  task automatic test_parity();
    int pe_b = pe_cnt1;
    int fe_b = fe_cnt1;
    uart_send(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    tests++; if ((pe_cnt1 - pe_b) != 1) begin fails++; $display("FAIL parity_bad_pulse: got %0d expected 1", pe_cnt1 - pe_b); end
    tests++; if (empty1 !== 1'b1) begin fails++; $display("FAIL parity_bad_empty: got %b expected 1", empty1); end
    uart_send(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    tests++; if (rd_data1 !== 8'h03 || empty1 !== 1'b0) begin fails++; $display("FAIL parity_good: got %h/%b expected 03/0", rd_data1, empty1); end
    tests++; if ((pe_cnt1 - pe_b) != 1 || (fe_cnt1 - fe_b) != 0) begin fails++; $display("FAIL parity_err_total: got pe %0d fe %0d expected 1 0", pe_cnt1 - pe_b, fe_cnt1 - fe_b); end
    pop(1'b1);
    tests++; if (empty1 !== 1'b1) begin fails++; $display("FAIL parity_pop_empty: got %b expected 1", empty1); end
  endtask

  task automatic test_overrun();
    int ov_b = ov_cnt0;
    logic [7:0] exp_b;
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h31 + 8'(i);
      uart_send(1'b0, exp_b, 1'b0, 1'b0, 1'b1);
    end
    tests++; if (count0 !== 3'd4 || full0 !== 1'b1) begin fails++; $display("FAIL fill_state: got count %0d full %b expected 4 1", count0, full0); end
    tests++; if ((ov_cnt0 - ov_b) != 0) begin fails++; $display("FAIL fill_overrun: got %0d expected 0", ov_cnt0 - ov_b); end
    uart_send(1'b0, 8'h35, 1'b0, 1'b0, 1'b1);
    tests++; if ((ov_cnt0 - ov_b) != 1) begin fails++; $display("FAIL overrun_pulse: got %0d expected 1", ov_cnt0 - ov_b); end
    tests++; if (count0 !== 3'd4 || full0 !== 1'b1) begin fails++; $display("FAIL overrun_state: got count %0d full %b expected 4 1", count0, full0); end
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h31 + 8'(i);
      tests++; if (rd_data0 !== exp_b) begin fails++; $display("FAIL drain_data[%0d]: got %h expected %h", i, rd_data0, exp_b); end
      pop(1'b0);
    end
    tests++; if (empty0 !== 1'b1 || full0 !== 1'b0 || count0 !== 3'd0) begin fails++; $display("FAIL drain_final: got empty %b full %b count %0d expected 1 0 0", empty0, full0, count0); end
    pop(1'b0);
    tests++; if (empty0 !== 1'b1 || count0 !== 3'd0) begin fails++; $display("FAIL underflow: got empty %b count %0d expected 1 0", empty0, count0); end
    uart_send(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
    tests++; if (rd_data0 !== 8'h66 || count0 !== 3'd1) begin fails++; $display("FAIL after_underflow: got %h/%0d expected 66/1", rd_data0, count0); end
    pop(1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] partial = 8'hA5;
    int fe_b;
    uart_send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    tests++; if (count0 !== 3'd1) begin fails++; $display("FAIL pre_reset_count: got %0d expected 1", count0); end
    rx0 = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      rx0 = partial[i];
      #(BIT_NS);
    end
    rx0 = partial[3];
    #(BIT_NS / 2);
    rst = 1'b0;
    #100;
    @(negedge clk);
    tests++; if (count0 !== 3'd0 || empty0 !== 1'b1 || full0 !== 1'b0) begin fails++; $display("FAIL midreset_state: got count %0d empty %b full %b expected 0 1 0", count0, empty0, full0); end
    tests++; if (rd_data0 !== 8'h00 || {fe0, pe0, ov0} !== 3'b0) begin fails++; $display("FAIL midreset_outputs: got %h/%b expected 00/000", rd_data0, {fe0, pe0, ov0}); end
    rx0 = 1'b1;
    rst = 1'b1;
    #(2 * BIT_NS);
    fe_b = fe_cnt0;
    uart_send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    tests++; if (rd_data0 !== 8'h5A || count0 !== 3'd1) begin fails++; $display("FAIL midreset_next: got %h/%0d expected 5a/1", rd_data0, count0); end
    tests++; if ((fe_cnt0 - fe_b) != 0) begin fails++; $display("FAIL midreset_fe: got %0d expected 0", fe_cnt0 - fe_b); end
    pop(1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_parity();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal 5..8, data bits per frame.
REQ-004 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, a power of 2 and at least 2.
REQ-006 SHALL have port clk  in  1  system clock; all logic on the rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port rx  in  1  serial line, idle high, asynchronous to clk.
REQ-009 SHALL have port rd_en  in  1  pop the head of the FIFO.
REQ-010 SHALL have port rd_data  out  8  head byte; bits above DATA_BITS-1 are 0.
REQ-011 SHALL have port empty  out  1  FIFO holds no bytes.
REQ-012 SHALL have port full  out  1  FIFO holds FIFO_DEPTH bytes.
REQ-013 SHALL have port count  out  $clog2(FIFO_DEPTH)+1  number of bytes held.
REQ-014 SHALL have port frame_err  out  1  one-clk pulse when the stop bit is sampled low.
REQ-015 SHALL have port parity_err  out  1  one-clk pulse on a parity mismatch.
REQ-016 SHALL have port overrun  out  1  one-clk pulse when a good byte arrives while the FIFO is full.

Function
REQ-017 SHALL pass rx through a 2-FF synchronizer, reset value 1, before any other use.
REQ-018 SHALL generate a 16x oversample tick every DIV = round(CLK_HZ/(BAUD*16)) clk (651 at the defaults).
REQ-019 SHALL use the FSM states IDLE, START, DATA, PAR, STOP and WAIT_IDLE.
REQ-020 SHALL leave IDLE for START on a falling edge of the synchronized rx, restarting the tick phase at that edge.
REQ-021 SHALL sample the start bit at tick 8 in START; a high sample is a glitch, returning to IDLE with no write and no error.
REQ-022 SHALL sample DATA_BITS data bits in DATA, LSB first, each 16 ticks after the previous sample.
REQ-023 SHALL enter PAR after DATA only when PARITY != 0, sample one parity bit, and otherwise go straight to STOP.
REQ-024 SHALL treat even parity as XOR(data, parity bit) = 0 and odd parity as XOR(data, parity bit) = 1.
REQ-025 SHALL sample the stop bit in STOP.
REQ-026 SHALL, when the stop bit is low, pulse frame_err, discard the byte, and go to WAIT_IDLE until rx is high.
REQ-027 SHALL, when the stop bit is high but parity is bad, pulse parity_err, discard the byte, and return to IDLE.
REQ-028 SHALL, when the frame is good and the FIFO is not full, write the byte so that empty falls 1 clk after the stop-bit sample.
REQ-029 SHALL, when the frame is good and the FIFO is full without a same-cycle rd_en, pulse overrun and leave the FIFO unchanged.
REQ-030 SHALL give the FIFO first-word fall-through: rd_data shows the head while !empty, and rd_en advances the head at the next edge.
REQ-031 SHALL ignore rd_en while empty, with no pointer change and no underflow.
REQ-032 SHALL, on a simultaneous write and read, perform both with count unchanged, including when full (no overrun).
REQ-033 SHALL wrap the read and write pointers modulo FIFO_DEPTH and keep count exact under every pattern of rd_en and writes.
REQ-034 SHALL raise at most one error pulse per frame; error pulses SHALL NOT be asserted in the same cycle as a write.

Reset
REQ-035 SHALL, while rst is low, force the FSM to IDLE, the synchronizer to 1, the tick counter to 0, both pointers and count to 0, empty=1, full=0, rd_data=0 and all pulse outputs to 0.
REQ-036 SHALL, on a reset in mid-frame, drop the partial byte and receive the next full frame correctly.

Verification
REQ-037 SHALL cover a single frame: defaults, send 0x72 ('r') at 104166 ns per bit -> empty=0, count=1, rd_data=0x72; after rd_en, empty=1.
REQ-038 SHALL cover a glitch: rx low for 2 us -> no write, frame_err=parity_err=0, FSM back in IDLE.
REQ-039 SHALL cover a framing error: 0x55 with the stop bit held low for 1 bit time -> one frame_err pulse, empty stays 1; the next good 0x41 is received.
REQ-040 SHALL cover parity: PARITY=1, 0x03 with parity bit 1 -> parity_err, discarded; 0x03 with parity bit 0 -> rd_data=0x03.
REQ-041 SHALL cover overrun: FIFO_DEPTH=4, send 0x31..0x35 with no reads -> full=1, count=4, one overrun pulse on 0x35; reads return 0x31..0x34 in order, then empty=1.
REQ-042 SHALL cover reset mid-frame: rst low during data bit 3 of 0xA5 -> all outputs at reset values; the following 0x5A is received intact.
